mop_add_scheduler: RTL

//  Sequences a multi-operand sum through one shared, clocked CLA adder instance by serial accumulation.

---
 rtl/add_tree_pkg.sv | 24 ++
 rtl/mop_add_scheduler_if.sv | 31 +++
 rtl/mop_lat_counter.sv | 25 ++
 rtl/mop_add_scheduler.sv | 117 +++++++++++
 4 files changed

// File: rtl/add_tree_pkg.sv
// Shared types and width helpers for the multi-operand add scheduler.
// Default configuration constants are used by the interface and bench.
package add_tree_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_MAX_OPS = 8;
    localparam int ADD_LAT_MAX = 7;
    localparam int LAT_W       = $clog2(ADD_LAT_MAX + 1);

    function automatic int cnt_width(input int max_ops);
        return $clog2(max_ops) + 1;
    endfunction

    // Wide enough that max_ops full-scale operands never carry out.
    function automatic int acc_width(input int width, input int max_ops);
        return width + $clog2(max_ops);
    endfunction

    localparam int CNT_W = $clog2(DEF_MAX_OPS) + 1;
    localparam int ACC_W = DEF_WIDTH + $clog2(DEF_MAX_OPS);

endpackage

// File: rtl/mop_add_scheduler_if.sv
// Job command, operand stream and result stream of the add scheduler.
// The slave side is the scheduler; the master side is the job source/sink.
interface mop_add_scheduler_if
    import add_tree_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_OPS = DEF_MAX_OPS,
    localparam int CNT_W  = cnt_width(MAX_OPS),
    localparam int ACC_W  = acc_width(WIDTH, MAX_OPS)
);
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             ovf;

    modport master (
        output start, op_count, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_sum, ovf
    );

    modport slave (
        input  start, op_count, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_sum, ovf
    );
endinterface

// File: rtl/mop_lat_counter.sv
// Loadable down-counter with a zero flag; times the adder latency window.
module mop_lat_counter
    import add_tree_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mop_add_scheduler.sv
// Serial-accumulation scheduler: feeds acc+operand through one external
// clocked adder per operand and returns the final sum on a valid/ready port.
module mop_add_scheduler
    import add_tree_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_OPS = DEF_MAX_OPS,
    parameter int ADD_LAT = 1,
    localparam int CNT_W  = cnt_width(MAX_OPS),
    localparam int ACC_W  = acc_width(WIDTH, MAX_OPS)
) (
    input  logic                clk,
    input  logic                rst,
    mop_add_scheduler_if.slave  bus,
    output logic [ACC_W-1:0]    add_a,
    output logic [ACC_W-1:0]    add_b,
    output logic                add_cin,
    output logic                add_req,
    input  logic [ACC_W-1:0]    add_sum,
    input  logic                add_cout
);
    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [ACC_W-1:0] acc;
    logic             lat_zero;

    assign add_cin     = 1'b0;
    assign bus.out_sum = acc;

    // Counter is loaded with ADD_LAT-1 so its zero flag marks the last WAIT cycle.
    mop_lat_counter u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ISSUE),
        .load_val (LAT_W'(ADD_LAT - 1)),
        .dec      (state == WAIT),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            remaining     <= '0;
            add_a         <= '0;
            add_b         <= '0;
            add_req       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        if (bus.op_count == '0) begin
                            remaining     <= '0;
                            bus.ovf       <= 1'b0;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            // Oversized jobs are clamped and flagged rather than rejected.
                            if (bus.op_count > CNT_W'(MAX_OPS)) begin
                                remaining <= CNT_W'(MAX_OPS);
                                bus.ovf   <= 1'b1;
                            end else begin
                                remaining <= bus.op_count;
                                bus.ovf   <= 1'b0;
                            end
                            bus.in_ready <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        add_a        <= acc;
                        add_b        <= ACC_W'(bus.in_data);
                        add_req      <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_req <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_zero) begin
                        acc       <= add_sum;
                        bus.ovf   <= bus.ovf | add_cout;
                        remaining <= remaining - 1'b1;
                        add_a     <= '0;
                        add_b     <= '0;
                        if (remaining == CNT_W'(1)) begin
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            bus.in_ready <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
